systemizer_host_port: RTL and testbench

- Host-side initiator for the systemizer block's memory and control interface.
- Accepts a byte stream from the host and writes it into the systemizer matrix memory, then pulses start and waits for done.
- On success, reads the whole memory back and streams it to the host with valid/ready backpressure.
- Sits between the chip pins (TT wrapper) and the systemizer instance, replacing the hard-wired rd/wr tie-offs.

---
 rtl/systemizer_host_port.sv | 219 +++++++++++++++++++++
 tb/tb_systemizer_host_port.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systemizer_host_port.sv
// rtl/systemizer_host_port.sv - host load/run/unload initiator for the systemizer matrix memory
module systemizer_host_port #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_go,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic [1:0]        result,
  output logic              sys_wr_en,
  output logic [ADDR_W-1:0] sys_wr_addr,
  output logic [DATA_W-1:0] sys_data_in,
  output logic              sys_rd_en,
  output logic [ADDR_W-1:0] sys_rd_addr,
  input  logic [DATA_W-1:0] sys_data_out,
  output logic              sys_start,
  input  logic              sys_done,
  input  logic              sys_success,
  input  logic              sys_fail
);

  // Word counters carry one extra bit so "all DEPTH words issued" is representable.
  localparam int CNT_W = ADDR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] NUM_WORDS = CNT_W'(DEPTH);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_OK   = 2'b01;
  localparam logic [1:0] RES_FAIL = 2'b10;
  localparam logic [1:0] RES_TMO  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_UNLOAD, S_FINISH
  } state_t;

  state_t state, state_d;

  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [CNT_W-1:0]  out_cnt, out_cnt_d;
  logic [TMO_W-1:0]  tmo, tmo_d;
  logic              data_phase;
  logic              hold_valid, hold_valid_d;
  logic [DATA_W-1:0] hold_data, hold_data_d;

  logic              in_ready_d, out_valid_d, wr_en_d, rd_en_d, start_d;
  logic [DATA_W-1:0] out_data_d, data_in_d;
  logic [ADDR_W-1:0] wr_addr_d, rd_addr_d;
  logic [1:0]        result_d;

  logic in_hs, out_hs, done_fail, tmo_hit, can_issue;

  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign done_fail = sys_done && (sys_fail || !sys_success);
  assign tmo_hit   = (tmo == TMO_LAST);
  // A new read is launched only when its data is guaranteed a slot: either the
  // output register or the one-word hold register catches it two cycles later.
  assign can_issue = !sys_rd_en && !hold_valid && (cnt < NUM_WORDS) &&
                     (!out_valid || out_ready);

  // Next-state decision for the load/run/unload sequence.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (cmd_go) state_d = S_LOAD;
      S_LOAD:   if (in_hs && cnt == LAST_WORD) state_d = S_START;
      S_START:  state_d = S_WAIT;
      S_WAIT: begin
        if (sys_done)     state_d = done_fail ? S_IDLE : S_UNLOAD;
        else if (tmo_hit) state_d = S_IDLE;
      end
      S_UNLOAD: if (out_hs && out_cnt == LAST_WORD) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values for every registered output and datapath register.
  always_comb begin
    in_ready_d   = in_ready;
    out_valid_d  = out_valid;
    out_data_d   = out_data;
    result_d     = result;
    wr_en_d      = 1'b0;
    wr_addr_d    = sys_wr_addr;
    data_in_d    = sys_data_in;
    rd_en_d      = 1'b0;
    rd_addr_d    = sys_rd_addr;
    start_d      = 1'b0;
    cnt_d        = cnt;
    out_cnt_d    = out_cnt;
    tmo_d        = tmo;
    hold_valid_d = hold_valid;
    hold_data_d  = hold_data;
    case (state)
      S_IDLE: begin
        in_ready_d   = 1'b0;
        out_valid_d  = 1'b0;
        hold_valid_d = 1'b0;
        if (cmd_go) begin
          result_d   = RES_NONE;
          cnt_d      = '0;
          in_ready_d = 1'b1;
        end
      end
      S_LOAD: begin
        if (in_hs) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt[ADDR_W-1:0];
          data_in_d = in_data;
          cnt_d     = cnt + CNT_W'(1);
          if (cnt == LAST_WORD) in_ready_d = 1'b0;
        end
      end
      S_START: begin
        start_d = 1'b1;
        tmo_d   = '0;
      end
      S_WAIT: begin
        tmo_d = tmo + TMO_W'(1);
        if (sys_done) begin
          if (done_fail) begin
            result_d = RES_FAIL;
          end else begin
            cnt_d     = '0;
            out_cnt_d = '0;
          end
        end else if (tmo_hit) begin
          result_d = RES_TMO;
        end
      end
      S_UNLOAD: begin
        if (can_issue) begin
          rd_en_d   = 1'b1;
          rd_addr_d = cnt[ADDR_W-1:0];
          cnt_d     = cnt + CNT_W'(1);
        end
        if (out_hs) out_cnt_d = out_cnt + CNT_W'(1);
        if (data_phase) begin
          // Read data is only present for one cycle, so park it if the host stalls.
          if (!out_valid || out_ready) begin
            out_data_d  = sys_data_out;
            out_valid_d = 1'b1;
          end else begin
            hold_data_d  = sys_data_out;
            hold_valid_d = 1'b1;
          end
        end else if (out_hs) begin
          if (hold_valid) begin
            out_data_d   = hold_data;
            hold_valid_d = 1'b0;
          end else begin
            out_valid_d = 1'b0;
          end
        end
      end
      S_FINISH: begin
        result_d    = RES_OK;
        out_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      result      <= RES_NONE;
      sys_wr_en   <= 1'b0;
      sys_wr_addr <= '0;
      sys_data_in <= '0;
      sys_rd_en   <= 1'b0;
      sys_rd_addr <= '0;
      sys_start   <= 1'b0;
      cnt         <= '0;
      out_cnt     <= '0;
      tmo         <= '0;
      data_phase  <= 1'b0;
      hold_valid  <= 1'b0;
      hold_data   <= '0;
    end else begin
      state       <= state_d;
      busy        <= (state_d != S_IDLE);
      in_ready    <= in_ready_d;
      out_valid   <= out_valid_d;
      out_data    <= out_data_d;
      result      <= result_d;
      sys_wr_en   <= wr_en_d;
      sys_wr_addr <= wr_addr_d;
      sys_data_in <= data_in_d;
      sys_rd_en   <= rd_en_d;
      sys_rd_addr <= rd_addr_d;
      sys_start   <= start_d;
      cnt         <= cnt_d;
      out_cnt     <= out_cnt_d;
      tmo         <= tmo_d;
      data_phase  <= sys_rd_en;
      hold_valid  <= hold_valid_d;
      hold_data   <= hold_data_d;
    end
  end

endmodule

// File: tb/tb_systemizer_host_port.sv
// tb/tb_systemizer_host_port.sv - scoreboard bench for systemizer_host_port
`timescale 1ns/1ps
module tb_systemizer_host_port;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 32;
  localparam int ADDR_W  = 5;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_go = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready = 1'b1;
  logic              busy;
  logic [1:0]        result;
  logic              sys_wr_en;
  logic [ADDR_W-1:0] sys_wr_addr;
  logic [DATA_W-1:0] sys_data_in;
  logic              sys_rd_en;
  logic [ADDR_W-1:0] sys_rd_addr;
  logic [DATA_W-1:0] sys_data_out = 8'hEE;
  logic              sys_start;
  logic              sys_done = 1'b0;
  logic              sys_success = 1'b0;
  logic              sys_fail = 1'b0;

  systemizer_host_port #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_go(cmd_go),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .result(result),
    .sys_wr_en(sys_wr_en), .sys_wr_addr(sys_wr_addr), .sys_data_in(sys_data_in),
    .sys_rd_en(sys_rd_en), .sys_rd_addr(sys_rd_addr), .sys_data_out(sys_data_out),
    .sys_start(sys_start), .sys_done(sys_done), .sys_success(sys_success),
    .sys_fail(sys_fail)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int wr_cnt = 0, rd_cnt = 0, out_cnt = 0, start_cnt = 0;
  int start_cyc = 0, last_wr_cyc = 0;

  logic [DATA_W-1:0]        mem [DEPTH];
  logic [ADDR_W+DATA_W-1:0] wr_q [$];
  logic [DATA_W-1:0]        out_q [$];
  logic [ADDR_W+DATA_W-1:0] exp_w;
  logic [ADDR_W-1:0]        rd_exp = '0;
  logic                     prev_stall = 1'b0, prev_rd = 1'b0, rd_pend = 1'b0;
  logic [DATA_W-1:0]        prev_out = '0;
  logic [ADDR_W-1:0]        rd_pend_addr = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // Systemizer memory model plus scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sys_wr_en) begin
        mem[sys_wr_addr] = sys_data_in;
        wr_cnt++;
        last_wr_cyc = cyc;
        if (wr_q.size() == 0) chk("wr_extra", 1, 0);
        else begin
          exp_w = wr_q.pop_front();
          chk("wr_addr", sys_wr_addr, exp_w[ADDR_W+DATA_W-1:DATA_W]);
          chk("wr_data", sys_data_in, exp_w[DATA_W-1:0]);
        end
      end
      if (sys_start) begin
        start_cnt++;
        start_cyc = cyc;
        chk("start_gap", cyc - last_wr_cyc, 1);
      end
      if (sys_rd_en) begin
        rd_cnt++;
        chk("rd_stall", prev_stall, 0);
        chk("rd_b2b", prev_rd, 0);
        chk("rd_addr", sys_rd_addr, rd_exp);
        rd_exp = rd_exp + 1'b1;
      end
      if (prev_stall) chk("out_hold", {out_valid, out_data}, {1'b1, prev_out});
      if (out_valid && out_ready) begin
        out_cnt++;
        if (out_q.size() == 0) chk("out_extra", 1, 0);
        else chk("out_data", out_data, out_q.pop_front());
      end
      prev_stall   = out_valid && !out_ready;
      prev_rd      = sys_rd_en;
      prev_out     = out_data;
      rd_pend      = sys_rd_en;
      rd_pend_addr = sys_rd_addr;
    end else begin
      prev_stall = 1'b0;
      prev_rd    = 1'b0;
      rd_pend    = 1'b0;
    end
  end

  // Read data is valid for exactly the cycle after sys_rd_en, garbage otherwise.
  always @(posedge clk) begin
    #1;
    sys_data_out = rd_pend ? mem[rd_pend_addr] : 8'hEE;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_go();
    tick();
    cmd_go = 1'b1;
    tick();
    cmd_go = 1'b0;
  endtask

  task automatic pulse_done(input bit succ, input bit fail);
    sys_done = 1'b1;
    sys_success = succ;
    sys_fail = fail;
    tick();
    sys_done = 1'b0;
    sys_success = 1'b0;
    sys_fail = 1'b0;
  endtask

  task automatic load(input int n, input int mul, input int add, input bit gaps,
                      input bit go_mid, input bit want_out);
    int i;
    int g;
    bit ph;
    i = 0; g = 0; ph = 1'b0;
    while (i < n && g < 400) begin
      tick();
      g++;
      ph = !ph;
      in_valid = gaps ? ph : 1'b1;
      in_data = 8'(i * mul + add);
      cmd_go = go_mid && (g == 12);
      if (in_valid && in_ready) begin
        wr_q.push_back({5'(i), in_data});
        if (want_out) out_q.push_back(in_data);
        i++;
      end
    end
    tick();
    in_valid = 1'b0;
    cmd_go = 1'b0;
    chk("load_count", i, n);
  endtask

  task automatic wait_start(input int prev);
    int g;
    g = 0;
    while (start_cnt == prev && g < 100) begin
      tick();
      g++;
    end
    chk("start_seen", start_cnt, prev + 1);
  endtask

  task automatic unload(input bit stall, input int o0);
    int g;
    int s;
    g = 0; s = 0;
    while (busy && g < 500) begin
      tick();
      g++;
      if (stall && (out_cnt - o0) >= 10 && s < 5) begin
        out_ready = 1'b0;
        s++;
      end else begin
        out_ready = 1'b1;
      end
    end
    out_ready = 1'b1;
    chk("unload_idle", busy, 0);
  endtask

  task automatic txn_ok(input string t, input int mul, input int add, input bit gaps,
                        input bit stall, input bit go_mid);
    int s0, w0, o0, r0;
    s0 = start_cnt; w0 = wr_cnt; o0 = out_cnt; r0 = rd_cnt;
    rd_exp = '0;
    pulse_go();
    chk({t, "_busy"}, busy, 1);
    load(DEPTH, mul, add, gaps, go_mid, 1'b1);
    wait_start(s0);
    repeat (4) tick();
    if (go_mid) begin
      cmd_go = 1'b1;
      tick();
      cmd_go = 1'b0;
      chk({t, "_go_in_wait"}, busy, 1);
    end
    pulse_done(1'b1, 1'b0);
    unload(stall, o0);
    chk({t, "_result"}, result, 1);
    chk({t, "_writes"}, wr_cnt - w0, DEPTH);
    chk({t, "_reads"}, rd_cnt - r0, DEPTH);
    chk({t, "_words"}, out_cnt - o0, DEPTH);
    chk({t, "_starts"}, start_cnt - s0, 1);
    chk({t, "_outq"}, out_q.size(), 0);
  endtask

  task automatic txn_fail(input string t, input bit succ, input bit fail);
    int s0, r0;
    s0 = start_cnt; r0 = rd_cnt;
    pulse_go();
    load(DEPTH, 3, 5, 1'b0, 1'b0, 1'b0);
    wait_start(s0);
    repeat (9) tick();
    pulse_done(succ, fail);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_result"}, result, 2);
    repeat (5) tick();
    chk({t, "_reads"}, rd_cnt - r0, 0);
    chk({t, "_held"}, result, 2);
  endtask

  initial begin
    int g;
    int s0, w0, r0, t_res;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ctrl", {busy, result, in_ready, out_valid, sys_wr_en, sys_rd_en, sys_start}, 0);
    chk("rst_data", {sys_wr_addr, sys_rd_addr, sys_data_in, out_data}, 0);
    rst_n = 1'b1;
    tick();

    txn_ok("t1", 1, 0, 1'b0, 1'b0, 1'b0);
    txn_ok("t2", 7, 3, 1'b1, 1'b1, 1'b0);
    txn_fail("f1", 1'b0, 1'b1);
    txn_fail("f2", 1'b1, 1'b1);
    txn_fail("f3", 1'b0, 1'b0);

    s0 = start_cnt;
    pulse_go();
    load(DEPTH, 5, 1, 1'b0, 1'b0, 1'b0);
    wait_start(s0);
    g = 0;
    while (result == 2'b00 && g < 100) begin
      @(negedge clk);
      g++;
    end
    t_res = cyc;
    chk("tmo_result", result, 3);
    chk("tmo_cycles", t_res - start_cyc, TIMEOUT);
    chk("tmo_busy", busy, 0);

    r0 = rd_cnt;
    tick();
    pulse_done(1'b1, 1'b0);
    repeat (3) tick();
    chk("idle_done_busy", busy, 0);
    chk("idle_done_result", result, 3);
    chk("idle_done_reads", rd_cnt - r0, 0);

    txn_ok("t3", 5, 9, 1'b0, 1'b0, 1'b1);

    w0 = wr_cnt;
    pulse_go();
    load(7, 1, 8'h40, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    chk("pre_rst_writes", wr_cnt - w0, 7);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ctrl", {busy, result, in_ready, out_valid, sys_wr_en, sys_rd_en, sys_start}, 0);
    chk("rst_mid_data", {sys_wr_addr, sys_rd_addr, sys_data_in, out_data}, 0);
    wr_q.delete();
    out_q.delete();
    tick();
    rst_n = 1'b1;
    tick();

    txn_ok("t4", 1, 8'h80, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
